// File: rtl/signature_analyzer.sv
// MISR response compactor for BIST: compacts scan-out while scan_en is high, then checks against GOLDEN.
// Optional macro SIG_CYCLE_CHECK_EN: match additionally requires cycle_count == EXP_CYCLES.
module signature_analyzer #(
  parameter int unsigned           WIDTH      = 16,
  parameter logic [WIDTH-1:0]      POLY       = 16'h1021,
  parameter logic [WIDTH-1:0]      SEED       = 16'h0000,
  parameter logic [WIDTH-1:0]      GOLDEN     = 16'h0000,
  parameter logic [15:0]           EXP_CYCLES = 16'd13026
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             scan_en,
  input  logic             bist_running,
  input  logic             bist_end,
  input  logic [WIDTH-1:0] scan_out,
  output logic [WIDTH-1:0] signature,
  output logic [15:0]      cycle_count,
  output logic             done,
  output logic             pass,
  output logic             fail
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] misr;
  logic [WIDTH-1:0] misr_next;
  logic [15:0]      cnt;
  logic [15:0]      cnt_next;
  logic             fb;
  logic             match;

  always_comb begin
    misr_next    = '0;
    fb           = misr[WIDTH-1];
    misr_next[0] = scan_out[0] ^ (POLY[0] & fb);
    for (int unsigned i = 1; i < WIDTH; i++) begin
      misr_next[i] = misr[i-1] ^ scan_out[i] ^ (POLY[i] & fb);
    end
  end

  always_comb begin
    cnt_next = (cnt == '1) ? cnt : cnt + 16'd1;
  end

`ifdef SIG_CYCLE_CHECK_EN
  always_comb begin
    match = (misr == GOLDEN) && (cnt == EXP_CYCLES);
  end
`else
  always_comb begin
    match = (misr == GOLDEN);
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      misr  <= SEED;
      cnt   <= '0;
      done  <= 1'b0;
      pass  <= 1'b0;
      fail  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          misr <= SEED;
          cnt  <= '0;
          done <= 1'b0;
          pass <= 1'b0;
          fail <= 1'b0;
          if (bist_running) state <= RUN;
        end
        RUN: begin
          if (bist_end) begin
            if (scan_en) begin
              misr <= misr_next;
              cnt  <= cnt_next;
            end
            state <= CHECK;
          end else if (!bist_running) begin
            // Abort: drop the partial signature immediately so IDLE never exposes it
            misr  <= SEED;
            cnt   <= '0;
            state <= IDLE;
          end else if (scan_en) begin
            misr <= misr_next;
            cnt  <= cnt_next;
          end
        end
        CHECK: begin
          done  <= 1'b1;
          pass  <= match;
          fail  <= ~match;
          state <= DONE;
        end
        DONE: begin
          if (bist_running) begin
            misr  <= SEED;
            cnt   <= '0;
            done  <= 1'b0;
            pass  <= 1'b0;
            fail  <= 1'b0;
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign signature   = misr;
  assign cycle_count = cnt;

endmodule

// File: tb/tb_signature_analyzer.sv
// Scoreboard bench for signature_analyzer: stimulus queues expected results, monitor checks them on done.
module tb_signature_analyzer;

  logic        clock = 1'b0;
  logic        reset;
  logic        scan_en;
  logic        bist_running;
  logic        bist_end;
  logic [15:0] scan_out;
  logic [15:0] signature, signature_b;
  logic [15:0] cycle_count, cycle_count_b;
  logic        done, pass, fail;
  logic        done_b, pass_b, fail_b;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        pass;
    logic        fail;
    logic        bad_fail;
    logic [15:0] sig;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  signature_analyzer #(.WIDTH(16), .POLY(16'h1021), .SEED(16'h0000),
                       .GOLDEN(16'h0000), .EXP_CYCLES(16'd13026)) dut (
    .clock(clock), .reset(reset), .scan_en(scan_en), .bist_running(bist_running),
    .bist_end(bist_end), .scan_out(scan_out), .signature(signature),
    .cycle_count(cycle_count), .done(done), .pass(pass), .fail(fail)
  );

  signature_analyzer #(.WIDTH(16), .POLY(16'h1021), .SEED(16'h0000),
                       .GOLDEN(16'h0001), .EXP_CYCLES(16'd13026)) dut_bad (
    .clock(clock), .reset(reset), .scan_en(scan_en), .bist_running(bist_running),
    .bist_end(bist_end), .scan_out(scan_out), .signature(signature_b),
    .cycle_count(cycle_count_b), .done(done_b), .pass(pass_b), .fail(fail_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: each rising done pops one expected result
  logic done_q = 1'b0;
  always @(negedge clock) begin
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pass",     32'(pass),        32'(e.pass));
        chk("sb_fail",     32'(fail),        32'(e.fail));
        chk("sb_sig",      32'(signature),   32'(e.sig));
        chk("sb_cnt",      32'(cycle_count), 32'(e.cnt));
        chk("sb_bad_fail", 32'(fail_b),      32'(e.bad_fail));
        chk("sb_bad_pass", 32'(pass_b),      32'(!e.bad_fail));
        chk("sb_bad_done", 32'(done_b),      32'd1);
      end
    end
    done_q = done;
  end

  task automatic start_run();
    bist_running = 1'b1; bist_end = 1'b0; scan_en = 1'b0; scan_out = '0;
    step();
  endtask

  task automatic end_run(input string tag);
    scan_en = 1'b0; scan_out = '0; bist_end = 1'b1; bist_running = 1'b0;
    step();
    chk({tag, "_lat1_done"}, 32'(done), 32'd0);
    bist_end = 1'b0;
    step();
    chk({tag, "_lat2_done"}, 32'(done), 32'd1);
  endtask

  // Controller-shaped run: ON cycles with zero data, one OFF gap driving all-ones (must be ignored)
  task automatic run_periods(input int periods, input int drop_at);
    for (int p = 0; p < periods; p++) begin
      for (int c = 0; c < ((p == drop_at) ? 25 : 26); c++) begin
        scan_en = 1'b1; scan_out = 16'h0000;
        step();
      end
      scan_en = 1'b0; scan_out = 16'hFFFF;
      step();
    end
  endtask

  initial begin
    exp_t e;
    reset = 1'b0; scan_en = 1'b0; bist_running = 1'b0; bist_end = 1'b0; scan_out = '0;
    repeat (3) begin
      scan_en      = 1'($urandom);
      bist_running = 1'($urandom);
      bist_end     = 1'($urandom);
      scan_out     = 16'($urandom);
      step();
    end
    chk("rst_sig",  32'(signature),   32'h0);
    chk("rst_cnt",  32'(cycle_count), 32'h0);
    chk("rst_done", 32'(done),        32'h0);
    chk("rst_pass", 32'(pass),        32'h0);
    chk("rst_fail", 32'(fail),        32'h0);

    reset = 1'b1;
    start_run();
    chk("idle_to_run_no_compact", 32'(cycle_count), 32'h0);

    scan_en = 1'b1; scan_out = 16'h0001;
    step();
    chk("first_update", 32'(signature), 32'h0001);
    scan_out = 16'h0000;
    repeat (15) step();
    chk("shift_sig_8000", 32'(signature),   32'h8000);
    chk("shift_cnt_16",   32'(cycle_count), 32'd16);
    step();
    chk("feedback_1021", 32'(signature),   32'h1021);
    chk("cnt_17",        32'(cycle_count), 32'd17);

    scan_en = 1'b0; scan_out = 16'hFFFF;
    repeat (3) step();
    chk("gap_sig_hold", 32'(signature),   32'h1021);
    chk("gap_cnt_hold", 32'(cycle_count), 32'd17);

    e = '{pass: 1'b0, fail: 1'b1, bad_fail: 1'b1, sig: 16'h1021, cnt: 16'd17};
    sb.push_back(e);
    end_run("directed");
    step();
    chk("done_hold", 32'(done), 32'd1);
    chk("sig_hold_in_done", 32'(signature), 32'h1021);

    start_run();
    chk("restart_done_clr", 32'(done),        32'd0);
    chk("restart_fail_clr", 32'(fail),        32'd0);
    chk("restart_seed",     32'(signature),   32'h0000);
    chk("restart_cnt",      32'(cycle_count), 32'd0);

    run_periods(501, -1);
    chk("full_cnt", 32'(cycle_count), 32'h32E2);
    e = '{pass: 1'b1, fail: 1'b0, bad_fail: 1'b1, sig: 16'h0000, cnt: 16'h32E2};
    sb.push_back(e);
    end_run("full");

    start_run();
    run_periods(501, 250);
`ifdef SIG_CYCLE_CHECK_EN
    e = '{pass: 1'b0, fail: 1'b1, bad_fail: 1'b1, sig: 16'h0000, cnt: 16'h32E1};
`else
    e = '{pass: 1'b1, fail: 1'b0, bad_fail: 1'b1, sig: 16'h0000, cnt: 16'h32E1};
`endif
    sb.push_back(e);
    end_run("dropped");

    start_run();
    scan_en = 1'b1; scan_out = 16'h00FF;
    step();
    step();
    chk("abort_pre_sig", 32'(signature),   32'h0101);
    chk("abort_pre_cnt", 32'(cycle_count), 32'd2);
    scan_en = 1'b0; bist_running = 1'b0; bist_end = 1'b0;
    step();
    step();
    chk("abort_sig",  32'(signature),   32'h0000);
    chk("abort_cnt",  32'(cycle_count), 32'd0);
    chk("abort_done", 32'(done),        32'd0);
    scan_en = 1'b1; scan_out = 16'hFFFF;
    step();
    chk("idle_holds_seed", 32'(signature), 32'h0000);

    start_run();
    scan_en = 1'b1; scan_out = 16'h0001;
    step();
`ifdef SIG_CYCLE_CHECK_EN
    e = '{pass: 1'b0, fail: 1'b1, bad_fail: 1'b1, sig: 16'h0001, cnt: 16'd1};
`else
    e = '{pass: 1'b0, fail: 1'b1, bad_fail: 1'b0, sig: 16'h0001, cnt: 16'd1};
`endif
    sb.push_back(e);
    end_run("short");

    reset = 1'b0;
    step();
    chk("rst_done_sig",  32'(signature),   32'h0);
    chk("rst_done_cnt",  32'(cycle_count), 32'h0);
    chk("rst_done_done", 32'(done),        32'h0);
    chk("rst_done_pass", 32'(pass),        32'h0);
    chk("rst_done_fail", 32'(fail),        32'h0);
    chk("rst_done_badf", 32'(fail_b),      32'h0);
    reset = 1'b1;

    for (int k = 0; k < 10 && sb.size() != 0; k++) step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
